// File: rtl/mod_counter_pkg.sv
// Shared constants and step encoding for the modulo counter family.
// Clock-style moduli live here so every stage agrees on them.
package mod_counter_pkg;

   localparam int SEC_MOD  = 60;
   localparam int MIN_MOD  = 60;
   localparam int HR24_MOD = 24;
   localparam int BCD_W    = 4;

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_CLEAR,
      ST_LOAD,
      ST_UP,
      ST_DOWN
   } step_e;

endpackage

// File: rtl/mod_counter_bin2bcd.sv
// Combinational 0..99 binary to two BCD digits.
// Shared by the counter and any display logic.
module bin2bcd
   import mod_counter_pkg::*;
(
   input  logic [6:0]       bin_i,
   output logic [BCD_W-1:0] tens_o,
   output logic [BCD_W-1:0] ones_o
);

   logic [6:0] rem;
   logic       unused_hi;

   // Compare chain keeps this free of a real divider.
   always_comb begin
      tens_o = '0;
      for (int k = 1; k < 10; k++) begin
         if (bin_i >= 7'(k * 10)) tens_o = BCD_W'(k);
      end
   end

   assign rem       = bin_i - ({3'b0, tens_o} << 3) - ({3'b0, tens_o} << 1);
   assign ones_o    = rem[BCD_W-1:0];
   assign unused_hi = ^rem[6:BCD_W];

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with clear, clamped load, cascade wrap
// and BCD digit outputs.
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int MODULUS = SEC_MOD,
   parameter int WIDTH   = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones
);

   if (MODULUS < 2 || MODULUS > 100) begin : g_bad_mod
      $error("mod_counter: MODULUS out of range 2..100");
   end
   if ((2 ** WIDTH) < MODULUS) begin : g_bad_width
      $error("mod_counter: WIDTH too small for MODULUS");
   end

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_c;
   logic             at_max, at_zero;
   step_e            op;

   assign at_max  = (count_q == MAX_C);
   assign at_zero = (count_q == '0);

   always_comb begin
      op = ST_HOLD;
      if (clear)     op = ST_CLEAR;
      else if (load) op = ST_LOAD;
      else if (en)   op = up ? ST_UP : ST_DOWN;
   end

   // Wrap is decided by compare so MODULUS == 2**WIDTH still works.
   always_comb begin
      count_d = count_q;
      wrap_c  = 1'b0;
      unique case (op)
         ST_CLEAR: count_d = '0;
         ST_LOAD:  count_d = ({1'b0, load_val} >= MOD_X) ? MAX_C : load_val;
         ST_UP: begin
            wrap_c  = at_max;
            count_d = at_max ? '0 : count_q + WIDTH'(1);
         end
         ST_DOWN: begin
            wrap_c  = at_zero;
            count_d = at_zero ? MAX_C : count_q - WIDTH'(1);
         end
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;
   assign wrap  = wrap_c & reset;

   logic [WIDTH+6:0] cnt_ext;
   logic [6:0]       bin;
   logic             unused_ext;

   assign cnt_ext    = {7'd0, count_q};
   assign bin        = cnt_ext[6:0];
   assign unused_ext = ^cnt_ext[WIDTH+6:7];

   bin2bcd u_bcd (
      .bin_i  (bin),
      .tens_o (tens),
      .ones_o (ones)
   );

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench: directed steps push expectations, a negedge
// monitor pops and compares against the live outputs.
module tb_mod_counter;
   import mod_counter_pkg::*;

   logic       clk;
   logic       reset_n;
   logic       en, up, clr, ld;
   logic [5:0] ld_val;
   logic [5:0] count;
   logic       wrap;
   logic [3:0] tens, ones;

   logic       c_en, c_up, c_clr, c_ld;
   logic [5:0] ls, lm;
   logic [4:0] lh;
   logic [5:0] s_cnt, m_cnt;
   logic [4:0] h_cnt;
   logic       s_w, m_w, h_w;
   logic [3:0] s_t, s_o, m_t, m_o, h_t, h_o;

   mod_counter dut (
      .clk(clk), .reset(reset_n), .en(en), .up(up),
      .clear(clr), .load(ld), .load_val(ld_val),
      .count(count), .wrap(wrap), .tens(tens), .ones(ones)
   );

   mod_counter #(.MODULUS(SEC_MOD), .WIDTH(6)) u_sec (
      .clk(clk), .reset(reset_n), .en(c_en), .up(c_up),
      .clear(c_clr), .load(c_ld), .load_val(ls),
      .count(s_cnt), .wrap(s_w), .tens(s_t), .ones(s_o)
   );

   mod_counter #(.MODULUS(MIN_MOD), .WIDTH(6)) u_min (
      .clk(clk), .reset(reset_n), .en(s_w), .up(c_up),
      .clear(c_clr), .load(c_ld), .load_val(lm),
      .count(m_cnt), .wrap(m_w), .tens(m_t), .ones(m_o)
   );

   mod_counter #(.MODULUS(HR24_MOD), .WIDTH(5)) u_hr (
      .clk(clk), .reset(reset_n), .en(m_w), .up(c_up),
      .clear(c_clr), .load(c_ld), .load_val(lh),
      .count(h_cnt), .wrap(h_w), .tens(h_t), .ones(h_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int    kind;
      string nm;
      int    a, b, c;
      bit    wa, wb, wc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   ok;

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (e.kind == 0) begin
            ok = (int'(count) == e.a) && (wrap == e.wa) &&
                 (int'(tens) == e.b) && (int'(ones) == e.c);
            if (!ok)
               $display("FAIL %s: got count=%0d wrap=%0b tens=%0d ones=%0d, want count=%0d wrap=%0b tens=%0d ones=%0d",
                        e.nm, count, wrap, tens, ones, e.a, e.wa, e.b, e.c);
         end else begin
            ok = (int'(s_cnt) == e.a) && (int'(m_cnt) == e.b) &&
                 (int'(h_cnt) == e.c) && (s_w == e.wa) &&
                 (m_w == e.wb) && (h_w == e.wc);
            if (!ok)
               $display("FAIL %s: got %0d:%0d:%0d wraps=%0b%0b%0b, want %0d:%0d:%0d wraps=%0b%0b%0b",
                        e.nm, h_cnt, m_cnt, s_cnt, h_w, m_w, s_w,
                        e.c, e.b, e.a, e.wc, e.wb, e.wa);
         end
         if (ok) n_pass++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Inputs apply to the current cycle; expectation is what the
   // outputs must show during it, before the next edge.
   task automatic m_step(input string nm, input bit r, input bit e_,
                         input bit u, input bit c, input bit l,
                         input int lv, input int xc, input bit xw);
      exp_t x;
      reset_n = r; en = e_; up = u; clr = c; ld = l; ld_val = 6'(lv);
      x.kind = 0; x.nm = nm; x.a = xc; x.b = xc / 10; x.c = xc % 10;
      x.wa = xw; x.wb = 1'b0; x.wc = 1'b0;
      sb.push_back(x);
      tick();
   endtask

   task automatic c_step(input string nm, input bit ce, input bit cl,
                         input int vs, input int vm, input int vh,
                         input int xs, input int xm, input int xh,
                         input bit ws, input bit wm, input bit wh);
      exp_t x;
      c_en = ce; c_ld = cl; ls = 6'(vs); lm = 6'(vm); lh = 5'(vh);
      x.kind = 1; x.nm = nm; x.a = xs; x.b = xm; x.c = xh;
      x.wa = ws; x.wb = wm; x.wc = wh;
      sb.push_back(x);
      tick();
   endtask

   initial begin
      reset_n = 1'b0; en = 0; up = 0; clr = 0; ld = 0; ld_val = '0;
      c_en = 0; c_up = 1'b1; c_clr = 0; c_ld = 0;
      ls = '0; lm = '0; lh = '0;
      tick();
      tick();

      m_step("rst_hold_wrap", 0, 1, 0, 0, 0, 0, 0, 0);
      m_step("rel_hold", 1, 0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 60; i++)
         m_step($sformatf("up_%0d", i), 1, 1, 1, 0, 0, 0, i, i == 59);
      m_step("up_rolled", 1, 0, 1, 0, 0, 0, 0, 0);

      m_step("dn_wrap", 1, 1, 0, 0, 0, 0, 0, 1);
      m_step("dn_59", 1, 1, 0, 0, 0, 0, 59, 0);
      m_step("dir_chg", 1, 1, 1, 0, 0, 0, 58, 0);
      m_step("en0_at_max", 1, 0, 1, 0, 0, 0, 59, 0);

      m_step("clear", 1, 0, 1, 1, 0, 0, 59, 0);
      m_step("ld63", 1, 0, 1, 0, 1, 63, 0, 0);
      m_step("ld17", 1, 0, 1, 0, 1, 17, 59, 0);
      m_step("ld60_en", 1, 1, 0, 0, 1, 60, 17, 0);
      m_step("ld17b", 1, 0, 1, 0, 1, 17, 59, 0);
      m_step("ld59", 1, 0, 1, 0, 1, 59, 17, 0);

      m_step("clr_ld_en", 1, 1, 1, 1, 1, 5, 59, 0);
      m_step("ld59b", 1, 0, 1, 0, 1, 59, 0, 0);
      m_step("ld_en_max", 1, 1, 1, 0, 1, 5, 59, 0);
      m_step("ld42", 1, 0, 1, 0, 1, 42, 5, 0);
      m_step("rst_mid", 0, 1, 1, 1, 1, 7, 42, 0);
      m_step("resume", 1, 1, 1, 0, 0, 0, 0, 0);
      m_step("resumed", 1, 0, 1, 0, 0, 0, 1, 0);

      c_step("c_ld", 0, 1, 58, 59, 23, 0, 0, 0, 0, 0, 0);
      c_step("c_58", 1, 0, 0, 0, 0, 58, 59, 23, 0, 0, 0);
      c_step("c_59", 1, 0, 0, 0, 0, 59, 59, 23, 1, 1, 1);
      c_step("c_roll", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      c_step("c_ld2", 0, 1, 59, 10, 5, 1, 0, 0, 0, 0, 0);
      c_step("c_min", 1, 0, 0, 0, 0, 59, 10, 5, 1, 0, 0);
      c_step("c_min_inc", 0, 0, 0, 0, 0, 0, 11, 5, 0, 0, 0);

      for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
      if (sb.size() > 0) begin
         n_chk++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
